// File: rtl/rx_cdr_filter_pkg.sv
// Shared types and default constants for the bang-bang CDR loop filter.
// The DCO code format is the one consumed by the receiver DCO clock.
package rx_cdr_filter_pkg;

    localparam int DCO_CODE_WIDTH = 10;
    typedef logic [DCO_CODE_WIDTH-1:0] DCO_CODE_FORMAT;

    typedef logic signed [1:0] PD_FORMAT;

    localparam int CDR_ACC_WIDTH = 24;
    localparam int CDR_ACC_FRAC  = 8;
    typedef logic signed [CDR_ACC_WIDTH-1:0] CDR_ACC_FORMAT;

    localparam int CDR_INIT_CODE   = 512;
    localparam int CDR_KP_ACQ      = 8;
    localparam int CDR_KP_TRK      = 2;
    localparam int CDR_KI          = 16;
    localparam int CDR_LOCK_WINDOW = 32;
    localparam int CDR_LOCK_THRESH = 4;

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } cdr_state_t;

endpackage

// File: rtl/rx_cdr_filter_bb_pd.sv
// Alexander bang-bang phase detector: one registered decision per sample strobe.
// The first sample after reset only primes d_prev and yields no decision.
module bb_pd
    import rx_cdr_filter_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_sample_en,
    input  logic     i_data,
    input  logic     i_edge,
    output PD_FORMAT o_pd,
    output logic     o_pd_valid
);

    logic     r_d_prev;
    logic     r_primed;
    PD_FORMAT r_pd;
    logic     r_pd_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d_prev   <= 1'b0;
            r_primed   <= 1'b0;
            r_pd       <= '0;
            r_pd_valid <= 1'b0;
        end else begin
            r_pd_valid <= i_sample_en;
            if (i_sample_en) begin
                r_d_prev <= i_data;
                r_primed <= 1'b1;
                if (!r_primed || (r_d_prev == i_data))
                    r_pd <= 2'sb00;
                else if (i_edge == i_data)
                    r_pd <= 2'sb01;   // clock late
                else
                    r_pd <= 2'sb11;   // clock early
            end
        end
    end

    assign o_pd       = r_pd;
    assign o_pd_valid = r_pd_valid;

endmodule

// File: rtl/rx_cdr_filter.sv
// Bang-bang CDR: phase detector, PI loop filter with clamped DCO code output,
// and a lock FSM that selects the proportional gain.
module rx_cdr_filter
    import rx_cdr_filter_pkg::*;
#(
    parameter int INIT_CODE   = CDR_INIT_CODE,
    parameter int KP_ACQ      = CDR_KP_ACQ,
    parameter int KP_TRK      = CDR_KP_TRK,
    parameter int KI          = CDR_KI,
    parameter int ACC_WIDTH   = CDR_ACC_WIDTH,
    parameter int ACC_FRAC    = CDR_ACC_FRAC,
    parameter int LOCK_WINDOW = CDR_LOCK_WINDOW,
    parameter int LOCK_THRESH = CDR_LOCK_THRESH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sample_en,
    input  logic           data_in,
    input  logic           edge_in,
    output DCO_CODE_FORMAT code,
    output PD_FORMAT       pd_out,
    output logic           pd_valid,
    output logic           lock
);

    localparam int XW = ACC_WIDTH + 2;
    localparam int CW = (LOCK_WINDOW > 1) ? $clog2(LOCK_WINDOW) : 1;
    localparam int BW = $clog2(LOCK_WINDOW + 1) + 1;
    localparam longint ACC_MAX_L = (longint'(1) << (ACC_WIDTH - 1)) - 1;
    localparam logic signed [XW-1:0] ACC_MAX  = XW'(ACC_MAX_L);
    localparam logic signed [XW-1:0] ACC_MIN  = -ACC_MAX;
    localparam logic signed [XW-1:0] CODE_MAX = XW'((1 << DCO_CODE_WIDTH) - 1);
    localparam logic signed [BW-1:0] THR      = BW'(LOCK_THRESH);

    PD_FORMAT w_pd;
    logic     w_pd_valid;

    bb_pd u_pd (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sample_en(sample_en),
        .i_data     (data_in),
        .i_edge     (edge_in),
        .o_pd       (w_pd),
        .o_pd_valid (w_pd_valid)
    );

    logic signed [ACC_WIDTH-1:0] r_integ;
    DCO_CODE_FORMAT              r_code;
    cdr_state_t                  r_state, w_state_next;
    logic [CW-1:0]               r_cnt, w_cnt_next;
    logic signed [BW-1:0]        r_bal, w_bal_next, w_bal_sum;

    logic signed [XW-1:0] w_pd_ext, w_kp, w_sum, w_integ_next, w_code_raw;
    DCO_CODE_FORMAT       w_code_next;

    always_comb begin
        w_pd_ext = {{(XW-2){w_pd[1]}}, w_pd};
        w_kp     = (r_state == ST_TRACK) ? XW'(KP_TRK) : XW'(KP_ACQ);
        w_sum    = {{2{r_integ[ACC_WIDTH-1]}}, r_integ} + w_pd_ext * XW'(KI);
        if (w_sum > ACC_MAX)
            w_integ_next = ACC_MAX;
        else if (w_sum < ACC_MIN)
            w_integ_next = ACC_MIN;
        else
            w_integ_next = w_sum;
        w_code_raw = XW'(INIT_CODE) + (w_integ_next >>> ACC_FRAC) + w_pd_ext * w_kp;
        if (w_code_raw < 0)
            w_code_next = '0;
        else if (w_code_raw > CODE_MAX)
            w_code_next = '1;
        else
            w_code_next = w_code_raw[DCO_CODE_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_integ <= '0;
            r_code  <= DCO_CODE_FORMAT'(INIT_CODE);
        end else if (w_pd_valid) begin
            r_integ <= w_integ_next[ACC_WIDTH-1:0];
            r_code  <= w_code_next;
        end
    end

    // The window-closing decision is folded into the balance before judging it.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bal_next   = r_bal;
        w_bal_sum    = r_bal + {{(BW-2){w_pd[1]}}, w_pd};
        if (w_pd_valid && (w_pd != 2'sb00)) begin
            if (r_cnt == CW'(LOCK_WINDOW - 1)) begin
                w_state_next = ((w_bal_sum <= THR) && (w_bal_sum >= -THR)) ? ST_TRACK : ST_ACQUIRE;
                w_cnt_next   = '0;
                w_bal_next   = '0;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
                w_bal_next = w_bal_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACQUIRE;
            r_cnt   <= '0;
            r_bal   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bal   <= w_bal_next;
        end
    end

    assign code     = r_code;
    assign pd_out   = w_pd;
    assign pd_valid = w_pd_valid;
    assign lock     = (r_state == ST_TRACK);

endmodule

// File: tb/tb_rx_cdr_filter.sv
// Directed self-checking bench for rx_cdr_filter with hand-computed expected codes.
module tb_rx_cdr_filter;
    import rx_cdr_filter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_en = 1'b0;
    logic data_in = 1'b0;
    logic edge_in = 1'b0;

    DCO_CODE_FORMAT code, code_hi, code_lo;
    PD_FORMAT       pd_out, pd_hi, pd_lo;
    logic           pd_valid, pd_valid_hi, pd_valid_lo;
    logic           lock, lock_hi, lock_lo;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rx_cdr_filter u_dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .data_in(data_in), .edge_in(edge_in),
        .code(code), .pd_out(pd_out), .pd_valid(pd_valid), .lock(lock)
    );

    rx_cdr_filter #(.INIT_CODE(1020)) u_hi (
        .clk(clk), .rst(rst), .sample_en(sample_en), .data_in(data_in), .edge_in(edge_in),
        .code(code_hi), .pd_out(pd_hi), .pd_valid(pd_valid_hi), .lock(lock_hi)
    );

    rx_cdr_filter #(.INIT_CODE(3)) u_lo (
        .clk(clk), .rst(rst), .sample_en(sample_en), .data_in(data_in), .edge_in(edge_in),
        .code(code_lo), .pd_out(pd_lo), .pd_valid(pd_valid_lo), .lock(lock_lo)
    );

    task automatic step(input logic en, input logic d, input logic e);
        sample_en = en;
        data_in   = d;
        edge_in   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b1);
        n_total++; if (code !== 10'd512) $display("FAIL reset_code: got %0d expected 512", code); else n_pass++;
        n_total++; if (lock !== 1'b0) $display("FAIL reset_lock: got %b expected 0", lock); else n_pass++;
        n_total++; if (pd_valid !== 1'b0) $display("FAIL reset_pd_valid: got %b expected 0", pd_valid); else n_pass++;
        n_total++; if (pd_out !== 2'b00) $display("FAIL reset_pd_out: got %0d expected 0", pd_out); else n_pass++;
        n_total++; if (code_hi !== 10'd1020) $display("FAIL reset_code_hi: got %0d expected 1020", code_hi); else n_pass++;
        n_total++; if (code_lo !== 10'd3) $display("FAIL reset_code_lo: got %0d expected 3", code_lo); else n_pass++;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (code !== 10'd512) $display("FAIL reset_release_code: got %0d expected 512", code); else n_pass++;
    endtask

    task automatic test_single_decision();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        n_total++; if (pd_out !== 2'b00 || pd_valid !== 1'b1) $display("FAIL prime_pd: got pd %0d valid %b expected 0 valid 1", pd_out, pd_valid); else n_pass++;
        step(1'b1, 1'b1, 1'b1);
        n_total++; if (pd_out !== 2'b01) $display("FAIL late_pd: got %0d expected 1", $signed(pd_out)); else n_pass++;
        n_total++; if (code !== 10'd512) $display("FAIL prime_code: got %0d expected 512", code); else n_pass++;
        step(1'b1, 1'b1, 1'b0);
        n_total++; if (code !== 10'd520) $display("FAIL late_code: got %0d expected 520", code); else n_pass++;
        n_total++; if (pd_out !== 2'b00) $display("FAIL notrans_pd: got %0d expected 0", $signed(pd_out)); else n_pass++;
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (code !== 10'd512) $display("FAIL notrans_code: got %0d expected 512", code); else n_pass++;
        n_total++; if (pd_valid !== 1'b0) $display("FAIL idle_pd_valid: got %b expected 0", pd_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'(k % 2), 1'(k % 2));
            if (k == 16) begin
                n_total++; if (code !== 10'd520) $display("FAIL b2b_15th_code: got %0d expected 520", code); else n_pass++;
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (code !== 10'd521) $display("FAIL b2b_16th_code: got %0d expected 521", code); else n_pass++;
    endtask

    task automatic test_saturation();
        int bad_hi = 0;
        int bad_lo = 0;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'(k % 2), 1'(k % 2));
            if (k >= 2 && code_hi !== 10'd1023) bad_hi++;
        end
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (bad_hi != 0) $display("FAIL sat_hi_stream: %0d updates not at 1023", bad_hi); else n_pass++;
        n_total++; if (code_hi !== 10'd1023) $display("FAIL sat_hi_code: got %0d expected 1023", code_hi); else n_pass++;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            step(1'b1, 1'(k % 2), 1'((k + 1) % 2));
            if (k >= 2 && code_lo !== 10'd0) bad_lo++;
        end
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (bad_lo != 0) $display("FAIL sat_lo_stream: %0d updates not at 0", bad_lo); else n_pass++;
        n_total++; if (code_lo !== 10'd0) $display("FAIL sat_lo_code: got %0d expected 0", code_lo); else n_pass++;
    endtask

    task automatic test_lock_window();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 32; j++)
            step(1'b1, 1'(j % 2), (j % 2 == 1) ? 1'b1 : 1'b1);
        n_total++; if (lock !== 1'b0) $display("FAIL lock_before_close: got %b expected 0", lock); else n_pass++;
        step(1'b1, 1'b1, 1'b1);
        n_total++; if (lock !== 1'b1) $display("FAIL lock_at_close: got %b expected 1", lock); else n_pass++;
        n_total++; if (code !== 10'd504) $display("FAIL lock_close_code: got %0d expected 504", code); else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        n_total++; if (code !== 10'd514) $display("FAIL track_kp_code: got %0d expected 514", code); else n_pass++;
        for (int j = 35; j <= 64; j++)
            step(1'b1, 1'(j % 2), 1'(j % 2));
        n_total++; if (lock !== 1'b1 || code !== 10'd515) $display("FAIL track_63_code: got lock %b code %0d expected lock 1 code 515", lock, code); else n_pass++;
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (lock !== 1'b0) $display("FAIL unlock_at_close: got %b expected 0", lock); else n_pass++;
        n_total++; if (code !== 10'd516) $display("FAIL unlock_close_code: got %0d expected 516", code); else n_pass++;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (code !== 10'd522) $display("FAIL reacq_kp_code: got %0d expected 522", code); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++)
            step(1'b1, 1'(k % 2), 1'(k % 2));
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (code !== 10'd521) $display("FAIL pre_reset_code: got %0d expected 521", code); else n_pass++;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        n_total++; if (code !== 10'd512 || lock !== 1'b0 || pd_valid !== 1'b0)
            $display("FAIL mid_reset_state: got code %0d lock %b valid %b expected 512 0 0", code, lock, pd_valid); else n_pass++;
        step(1'b1, 1'b1, 1'b1);
        n_total++; if (pd_out !== 2'b00 || pd_valid !== 1'b1) $display("FAIL reprime_pd: got %0d valid %b expected 0 valid 1", $signed(pd_out), pd_valid); else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        n_total++; if (pd_out !== 2'b01 || code !== 10'd512) $display("FAIL post_reset_pd: got pd %0d code %0d expected 1 512", $signed(pd_out), code); else n_pass++;
        step(1'b0, 1'b0, 1'b0);
        n_total++; if (code !== 10'd520) $display("FAIL post_reset_code: got %0d expected 520", code); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_decision();
        test_back_to_back();
        test_saturation();
        test_lock_window();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
